// File: rtl/img_metadata_header_parser.sv
// img_metadata_header_parser: reassembles the 48-bit metadata trailer from the dozen stream
module img_metadata_header_parser #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W = 7
) (
  input  logic        sysClk,
  input  logic        reset,
  input  logic [11:0] dozen_in,
  input  logic        dozen_in_valid,
  input  logic        header_expected,
  output logic [1:0]  compression,
  output logic        RGB,
  output logic        cam_id,
  output logic [27:0] timestamp,
  output logic [15:0] trigger_index,
  output logic        metadata_valid,
  output logic        busy,
  output logic        header_error,
  output logic [15:0] header_count
);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_nx;
  logic [47:0] sr, sr_nx;
  logic [1:0] cnt, cnt_nx;
  logic [TO_W-1:0] gap, gap_nx;
  logic hdr_prev, hdr_rise, done, abort;
  assign hdr_rise = header_expected & ~hdr_prev;
  assign busy = state == COLLECT;
  // next state: restart beats completion, completion beats timeout
  always_comb begin
    state_nx = state;
    sr_nx = sr;
    cnt_nx = cnt;
    gap_nx = gap;
    done = 1'b0;
    abort = 1'b0;
    if (hdr_rise) begin
      state_nx = COLLECT;
      cnt_nx = '0;
      gap_nx = '0;
      abort = state == COLLECT;
    end else if (state == COLLECT) begin
      if (dozen_in_valid) begin
        sr_nx = {sr[35:0], dozen_in};
        cnt_nx = cnt + 2'd1;
        gap_nx = '0;
        done = cnt == 2'd3;
        state_nx = done ? IDLE : COLLECT;
      end else if (gap + 1'b1 == TO_W'(TIMEOUT_CYCLES)) begin
        abort = 1'b1;
        gap_nx = '0;
        state_nx = IDLE;
      end else begin
        gap_nx = gap + 1'b1;
      end
    end
  end
  // state register
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // capture datapath, edge history and output registers
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      sr <= '0;
      cnt <= '0;
      gap <= '0;
      hdr_prev <= 1'b0;
      compression <= '0;
      RGB <= 1'b0;
      cam_id <= 1'b0;
      timestamp <= '0;
      trigger_index <= '0;
      metadata_valid <= 1'b0;
      header_error <= 1'b0;
      header_count <= '0;
    end else begin
      sr <= sr_nx;
      cnt <= cnt_nx;
      gap <= gap_nx;
      hdr_prev <= header_expected;
      metadata_valid <= done;
      header_error <= abort;
      if (done) begin
        {compression, RGB, cam_id, timestamp, trigger_index} <= sr_nx;
        header_count <= header_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_img_metadata_header_parser.sv
// tb_img_metadata_header_parser: directed checks of trailer capture, timeout, restart, wrap and reset
module tb_img_metadata_header_parser;
  logic sysClk = 1'b0;
  logic reset = 1'b1;
  logic [11:0] dozen_in = '0;
  logic dozen_in_valid = 1'b0;
  logic header_expected = 1'b0;
  logic [1:0] compression;
  logic RGB, cam_id;
  logic [27:0] timestamp;
  logic [15:0] trigger_index;
  logic metadata_valid, busy, header_error;
  logic [15:0] header_count;
  int n_vec = 0;
  int n_bad = 0;
  int he_seen = 0;
  int mv_seen = 0;
  int he0, mv0;

  img_metadata_header_parser #(.TIMEOUT_CYCLES(64), .TO_W(7)) dut (
    .sysClk(sysClk), .reset(reset), .dozen_in(dozen_in), .dozen_in_valid(dozen_in_valid),
    .header_expected(header_expected), .compression(compression), .RGB(RGB), .cam_id(cam_id),
    .timestamp(timestamp), .trigger_index(trigger_index), .metadata_valid(metadata_valid),
    .busy(busy), .header_error(header_error), .header_count(header_count)
  );

  always #5 sysClk = ~sysClk;

  task automatic tick();
    @(posedge sysClk);
    #1;
    he_seen += int'(header_error);
    mv_seen += int'(metadata_valid);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    header_expected = 1'b1;
    tick();
    header_expected = 1'b0;
  endtask

  task automatic send(input logic [11:0] d);
    dozen_in = d;
    dozen_in_valid = 1'b1;
    tick();
    dozen_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_fields(input string tag, input logic [47:0] exp);
    check(tag, {16'h0, compression, RGB, cam_id, timestamp, trigger_index}, {16'h0, exp});
  endtask

  initial begin
    idle(2);
    check("reset_outputs", {compression, RGB, cam_id, timestamp, trigger_index, metadata_valid, busy, header_error, header_count},
          '0);
    reset = 1'b0;
    idle(2);
    check("idle_busy", busy, 0);

    pulse();
    check("nominal_busy", busy, 1);
    send(12'hAAB);
    send(12'hCDE);
    send(12'hF11);
    check("nominal_mv_early", metadata_valid, 0);
    send(12'h234);
    check("nominal_mv", metadata_valid, 1);
    check("nominal_compression", compression, 2);
    check("nominal_rgb", RGB, 1);
    check("nominal_cam_id", cam_id, 0);
    check("nominal_timestamp", timestamp, 28'hABCDEF1);
    check("nominal_trigger", trigger_index, 16'h1234);
    check("nominal_count", header_count, 1);
    check("nominal_busy_after", busy, 0);
    tick();
    check("nominal_mv_one_cycle", metadata_valid, 0);

    he0 = he_seen;
    mv0 = mv_seen;
    for (int i = 0; i < 5; i++) send(12'hFFF - 12'(i));
    check("pixels_ignored_busy", busy, 0);
    check("pixels_no_mv", mv_seen - mv0, 0);
    pulse();
    send(12'hAAB); idle(3);
    send(12'hCDE); idle(3);
    send(12'hF11); idle(3);
    send(12'h234);
    check("gapped_mv", metadata_valid, 1);
    check_fields("gapped_fields", 48'hAABCDEF11234);
    check("gapped_count", header_count, 2);
    check("gapped_no_error", he_seen - he0, 0);
    tick();

    he0 = he_seen;
    mv0 = mv_seen;
    pulse();
    send(12'h555);
    send(12'h666);
    idle(63);
    check("timeout_not_yet", he_seen - he0, 0);
    check("timeout_busy_before", busy, 1);
    tick();
    check("timeout_error", header_error, 1);
    check("timeout_idle", busy, 0);
    idle(6);
    check("timeout_error_once", he_seen - he0, 1);
    check("timeout_no_mv", mv_seen - mv0, 0);
    check_fields("timeout_fields_hold", 48'hAABCDEF11234);
    check("timeout_count_hold", header_count, 2);

    he0 = he_seen;
    pulse();
    send(12'h111);
    send(12'h222);
    pulse();
    check("restart_error", header_error, 1);
    check("restart_busy", busy, 1);
    send(12'hAAB);
    send(12'hCDE);
    check("restart_no_early_mv", mv_seen - mv0, 0);
    send(12'hF11);
    send(12'h234);
    check("restart_mv", metadata_valid, 1);
    check_fields("restart_fields", 48'hAABCDEF11234);
    check("restart_count", header_count, 3);
    check("restart_error_once", he_seen - he0, 1);
    tick();

    pulse();
    send(12'h5A5);
    send(12'h123);
    send(12'h456);
    send(12'h789);
    check("pattern2_mv", metadata_valid, 1);
    check("pattern2_compression", compression, 1);
    check("pattern2_rgb", RGB, 0);
    check("pattern2_cam_id", cam_id, 1);
    check("pattern2_timestamp", timestamp, 28'hA512345);
    check("pattern2_trigger", trigger_index, 16'h6789);
    check("pattern2_count", header_count, 4);
    tick();

    force dut.header_count = 16'hFFFF;
    #1;
    release dut.header_count;
    he0 = he_seen;
    header_expected = 1'b1;
    tick();
    send(12'h0C3);
    send(12'h00F);
    send(12'hEDC);
    send(12'hBA9);
    check("wrap_mv", metadata_valid, 1);
    check("wrap_count", header_count, 16'h0000);
    check_fields("wrap_fields", 48'h0C300FEDCBA9);
    idle(3);
    check("held_high_no_retrigger", busy, 0);
    check("held_high_no_error", he_seen - he0, 0);
    header_expected = 1'b0;
    tick();

    mv0 = mv_seen;
    pulse();
    send(12'h321);
    send(12'h654);
    check("midcollect_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {compression, RGB, cam_id, timestamp, trigger_index, metadata_valid, busy, header_error, header_count},
          '0);
    tick();
    reset = 1'b0;
    send(12'h987);
    send(12'hCBA);
    idle(5);
    check("post_reset_no_mv", mv_seen - mv0, 0);
    check("post_reset_idle", busy, 0);
    check("post_reset_count", header_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
